// File: rtl/mem_bus_interconnect.sv
// Single-master to N-slave memory bus interconnect with address decode,
// per-slave strobes, ack/timeout handling and a registered master response.
module mem_bus_interconnect #(
    parameter int N_SLAVES   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_LSB    = 28,
    parameter int TIMEOUT    = 15
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           m_rd_en_i,
    input  logic                           m_wr_en_i,
    input  logic [ADDR_WIDTH-1:0]          m_addr_i,
    input  logic [DATA_WIDTH-1:0]          m_data_i,
    output logic [DATA_WIDTH-1:0]          m_data_o,
    output logic                           m_ack_o,
    output logic                           m_err_o,
    output logic [N_SLAVES-1:0]            s_rd_en_o,
    output logic [N_SLAVES-1:0]            s_wr_en_o,
    output logic [ADDR_WIDTH-1:0]          s_addr_o,
    output logic [DATA_WIDTH-1:0]          s_data_o,
    input  logic [N_SLAVES*DATA_WIDTH-1:0] s_data_i,
    input  logic [N_SLAVES-1:0]            s_ack_i
);

    localparam int              SEL_W   = $clog2(N_SLAVES);
    localparam logic [SEL_W:0]  N_S     = N_SLAVES[SEL_W:0];
    localparam logic [7:0]      TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        ERR
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    wr_q;
    logic [SEL_W-1:0]        sel_q;
    logic [7:0]              cnt_q;

    logic [SEL_W-1:0]        sel_in;
    logic                    req;
    logic                    bad;
    logic [N_SLAVES-1:0]     sel_oh;
    logic                    ack_hit;
    logic [DATA_WIDTH-1:0]   rdata_sel;
    logic                    timeout_hit;

    assign sel_in      = m_addr_i[SEL_LSB +: SEL_W];
    assign req         = m_rd_en_i | m_wr_en_i;
    assign bad         = (m_rd_en_i & m_wr_en_i) | ({1'b0, sel_in} >= N_S);
    assign timeout_hit = (cnt_q == TO_LAST);
    assign s_addr_o    = addr_q;
    assign s_data_o    = wdata_q;

    // Explicit decode keeps an out-of-range select from ever matching a slave
    always_comb begin
        sel_oh    = '0;
        ack_hit   = 1'b0;
        rdata_sel = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (sel_q == SEL_W'(k)) begin
                sel_oh[k] = 1'b1;
                ack_hit   = s_ack_i[k];
                rdata_sel = s_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        s_rd_en_o = '0;
        s_wr_en_o = '0;
        m_ack_o   = 1'b0;
        m_err_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = bad ? ERR : WAIT;
                end
            end
            WAIT: begin
                s_rd_en_o = wr_q ? '0 : sel_oh;
                s_wr_en_o = wr_q ? sel_oh : '0;
                if (ack_hit) begin
                    state_d = RESP;
                end else if (timeout_hit) begin
                    state_d = ERR;
                end
            end
            RESP: begin
                m_ack_o = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                m_ack_o = 1'b1;
                m_err_o = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Response data is loaded on the edge that enters RESP/ERR, zero otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            sel_q    <= '0;
            cnt_q    <= '0;
            m_data_o <= '0;
        end else begin
            m_data_o <= '0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        addr_q  <= m_addr_i;
                        wdata_q <= m_data_i;
                        wr_q    <= m_wr_en_i;
                        sel_q   <= sel_in;
                        cnt_q   <= '0;
                        if (bad) begin
                            m_data_o <= '1;
                        end
                    end
                end
                WAIT: begin
                    if (ack_hit) begin
                        m_data_o <= wr_q ? '0 : rdata_sel;
                    end else if (timeout_hit) begin
                        m_data_o <= '1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_bus_interconnect.md
MEM_BUS_INTERCONNECT -- requirements
Module: mem_bus_interconnect

Interface
REQ-001 SHALL have parameter N_SLAVES, default 4, number of slave ports (legal range 2..16).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data width.
REQ-004 SHALL have parameter SEL_LSB, default 28, lowest address bit of the slave-select field; the field is clog2(N_SLAVES) bits wide.
REQ-005 SHALL have parameter TIMEOUT, default 15, maximum number of WAIT cycles before error (legal range 1..255).
REQ-006 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have ports m_rd_en_i / m_wr_en_i  input  1 each  master read / write request.
REQ-009 SHALL have ports m_addr_i  input  ADDR_WIDTH and m_data_i  input  DATA_WIDTH  master address / write data.
REQ-010 SHALL have ports m_data_o  output  DATA_WIDTH and m_ack_o, m_err_o  output  1 each  master read data / completion / error.
REQ-011 SHALL have ports s_rd_en_o, s_wr_en_o  output  N_SLAVES  one-hot per-slave strobes.
REQ-012 SHALL have ports s_addr_o  output  ADDR_WIDTH and s_data_o  output  DATA_WIDTH, shared by all slaves.
REQ-013 SHALL have ports s_data_i  input  N_SLAVES*DATA_WIDTH (slave k at bits [k*DATA_WIDTH +: DATA_WIDTH]) and s_ack_i  input  N_SLAVES.

Function
REQ-014 SHALL implement states IDLE, WAIT, RESP, ERR.
REQ-015 IDLE: on rising edge with exactly one of m_rd_en_i/m_wr_en_i high, SHALL latch addr, wdata, op and select index.
REQ-016 If select index >= N_SLAVES, or both m_rd_en_i and m_wr_en_i are high, SHALL go to ERR; otherwise to WAIT.
REQ-017 WAIT: SHALL drive the selected slave's strobe for the latched op, and s_addr_o/s_data_o from latched values; all other strobes SHALL be 0.
REQ-018 WAIT: when s_ack_i of the selected slave is sampled high, SHALL capture its s_data_i slice (reads) and go to RESP; acks from non-selected slaves SHALL be ignored.
REQ-019 WAIT: a counter SHALL be cleared on WAIT entry and incremented each WAIT cycle without ack; after TIMEOUT WAIT cycles without ack, SHALL go to ERR; ack in the final WAIT cycle has priority over timeout.
REQ-020 RESP: SHALL assert m_ack_o for exactly one cycle; m_data_o = captured data for reads, 0 for writes; then IDLE.
REQ-021 ERR: SHALL assert m_ack_o and m_err_o together for exactly one cycle with m_data_o = all-ones; then IDLE.
REQ-022 Latency: request sampled at edge N, zero-wait slave acked in first WAIT cycle -> m_ack_o high in cycle after edge N+1 (2 cycles request-to-ack).
REQ-023 Master requests SHALL be ignored outside IDLE; back-to-back transactions SHALL be accepted in the cycle after RESP/ERR.
REQ-024 Outside WAIT, all slave strobes SHALL be 0; m_ack_o, m_err_o SHALL be 0 outside RESP/ERR; m_data_o SHALL be registered.

Reset
REQ-025 On rst_n low, SHALL immediately enter IDLE and clear all outputs, latches and counter to 0, including mid-transaction; an in-flight transfer SHALL be dropped without m_ack_o.
REQ-026 After rst_n deasserts, the first request SHALL be accepted on the first rising edge.

Verification
REQ-027 Read slave 1 (addr 0x1000_0010), slave acks in first WAIT cycle with 0xCAFE_F00D -> s_rd_en_o=4'b0010 for 1 cycle, m_ack_o 1 cycle, m_data_o=0xCAFE_F00D, m_err_o=0.
REQ-028 Write 0x1234_5678 to slave 3 (addr 0x3000_0004), ack after 3 WAIT cycles -> s_wr_en_o=4'b1000 for 3 cycles, s_data_o=0x1234_5678, m_ack_o with m_data_o=0.
REQ-029 TIMEOUT=4, slave never acks -> 4 WAIT cycles, then m_ack_o=m_err_o=1 for 1 cycle, m_data_o=0xFFFF_FFFF, strobe dropped.
REQ-030 N_SLAVES=3, addr 0x3000_0000 -> direct to ERR, no slave strobe asserted; same for simultaneous rd+wr request.
REQ-031 Non-selected slave 2 acks while slave 0 selected -> ignored, transaction completes only on slave 0 ack.
REQ-032 rst_n low during WAIT -> strobes and state cleared asynchronously, no m_ack_o; next request after release completes normally.
